// File: rtl/seg_bus_arbiter_pkg.sv
// Shared encodings for the segment bus arbiter: FSM states, blank pattern
// and active-low digit enable codes.
package seg_bus_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_G0   = 2'd1;
  localparam logic [1:0] ST_G1   = 2'd2;

  localparam logic [6:0] BLANK   = 7'h7F;

  localparam logic [1:0] AN_NONE = 2'b11;
  localparam logic [1:0] AN_D0   = 2'b10;
  localparam logic [1:0] AN_D1   = 2'b01;

endpackage

// File: rtl/seg_bus_arbiter_dwell.sv
// Dwell slot counter: counts cycles within one grant slot and flags the
// final cycle of the slot. Saturates at the last cycle, never wraps.
module seg_dwell_counter #(
  parameter int P_DWELL = 1000,
  parameter int P_CNT_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  output logic [P_CNT_W-1:0] cnt,
  output logic               last_cycle
);

  localparam logic [P_CNT_W-1:0] CNT_LAST = P_CNT_W'(P_DWELL - 1);

  logic [P_CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (en && (cnt_reg != CNT_LAST)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt        = cnt_reg;
  assign last_cycle = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/seg_bus_arbiter.sv
// Round-robin arbiter sharing one registered segment bus between two
// requesters, each grant bounded by a dwell slot.
module seg_bus_arbiter
  import seg_bus_arbiter_pkg::*;
#(
  parameter int P_DATA  = 7,
  parameter int P_DWELL = 1000,
  parameter int P_CNT_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [P_DATA-1:0] ent0,
  input  logic [P_DATA-1:0] ent1,
  output logic              sel,
  output logic              gnt0,
  output logic              gnt1,
  output logic [P_DATA-1:0] out,
  output logic [1:0]        an,
  output logic              busy
);

  localparam logic [P_DATA-1:0] OUT_BLANK = {P_DATA{1'b1}};

  logic [1:0]        state_reg, state_next;
  logic              last_reg, last_next;
  logic              sel_reg, gnt0_reg, gnt1_reg, busy_reg;
  logic [1:0]        an_reg, an_next;
  logic [P_DATA-1:0] out_reg, out_next;
  logic              cnt_clr, cnt_en, slot_end;
  logic [P_CNT_W-1:0] cnt;

  seg_dwell_counter #(
    .P_DWELL (P_DWELL),
    .P_CNT_W (P_CNT_W)
  ) u_dwell (
    .clk        (clk),
    .rst        (rst),
    .clr        (cnt_clr),
    .en         (cnt_en),
    .cnt        (cnt),
    .last_cycle (slot_end)
  );

  always_comb begin
    state_next = state_reg;
    cnt_clr    = 1'b1;
    cnt_en     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req0 && req1)  state_next = last_reg ? ST_G0 : ST_G1;
        else if (req0)     state_next = ST_G0;
        else if (req1)     state_next = ST_G1;
      end
      ST_G0: begin
        if (req0) begin
          if (!slot_end) begin
            cnt_en  = 1'b1;
            cnt_clr = 1'b0;
          end else if (req1) begin
            state_next = ST_G1;
          end
        end else begin
          state_next = req1 ? ST_G1 : ST_IDLE;
        end
      end
      ST_G1: begin
        if (req1) begin
          if (!slot_end) begin
            cnt_en  = 1'b1;
            cnt_clr = 1'b0;
          end else if (req0) begin
            state_next = ST_G0;
          end
        end else begin
          state_next = req0 ? ST_G0 : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so a new grant and its data
  // appear on the same edge, with no blank cycle between G0 and G1.
  always_comb begin
    last_next = last_reg;
    an_next   = AN_NONE;
    out_next  = OUT_BLANK;
    case (state_next)
      ST_G0: begin
        last_next = 1'b0;
        an_next   = AN_D0;
        out_next  = ent0;
      end
      ST_G1: begin
        last_next = 1'b1;
        an_next   = AN_D1;
        out_next  = ent1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      last_reg  <= 1'b1;
      sel_reg   <= 1'b0;
      gnt0_reg  <= 1'b0;
      gnt1_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      an_reg    <= AN_NONE;
      out_reg   <= OUT_BLANK;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      sel_reg   <= (state_next == ST_G1);
      gnt0_reg  <= (state_next == ST_G0);
      gnt1_reg  <= (state_next == ST_G1);
      busy_reg  <= (state_next != ST_IDLE);
      an_reg    <= an_next;
      out_reg   <= out_next;
    end
  end

  assign sel  = sel_reg;
  assign gnt0 = gnt0_reg;
  assign gnt1 = gnt1_reg;
  assign busy = busy_reg;
  assign an   = an_reg;
  assign out  = out_reg;

endmodule

// File: doc/seg_bus_arbiter.md
Name: seg_bus_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 7-bit segment bus between two requesters.
- Owns the 2:1 select, the digit enables and the registered bus output; no requester drives the bus directly.
- Each grant lasts a bounded dwell slot, so two display sources can time-share a single segment driver.
- Segments are active-low; the blank pattern is 7'h7F.

Parameters:
P_DATA, 7, width of segment data buses.
P_DWELL, 1000, maximum cycles per grant slot; legal range 1..2^P_CNT_W.
P_CNT_W, 10, dwell counter width; 2^P_CNT_W >= P_DWELL is required.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
req0  input  1  requester 0 wants the bus; level, held while data valid.
req1  input  1  requester 1 wants the bus.
ent0  input  P_DATA  segment data of requester 0.
ent1  input  P_DATA  segment data of requester 1.
sel  output  1  current source select: 0 = ent0, 1 = ent1.
gnt0  output  1  requester 0 owns the bus.
gnt1  output  1  requester 1 owns the bus.
out  output  P_DATA  registered segment bus.
an  output  2  active-low digit enables: 2'b10 = digit 0, 2'b01 = digit 1, 2'b11 = none.
busy  output  1  high whenever gnt0 or gnt1 is high.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst, sampled on the rising edge.
- All outputs are registered.
- Reset values: state IDLE; sel 0; gnt0 0; gnt1 0; out 7'h7F; an 2'b11; busy 0; dwell counter 0; round-robin pointer last = 1, so req0 wins the first tie.
- States:
  - IDLE: gnt = 00, an = 11, out = 7'h7F.
  - G0: gnt0 = 1, sel = 0, an = 10.
  - G1: gnt1 = 1, sel = 1, an = 01.
- IDLE transitions:
  - Only req0 -> G0. Only req1 -> G1.
  - Both requesting -> the requester not equal to last. Neither -> stay in IDLE.
- Gx, own req high and cnt < P_DWELL-1: stay, cnt += 1.
- Gx, own req high and cnt == P_DWELL-1 (slot end):
  - Other req high -> switch to the other grant, cnt = 0.
  - Else -> stay in Gx, cnt = 0 (a new slot starts).
- Gx, own req low (early release, any cnt): other req high -> other grant; else -> IDLE. cnt = 0 in both cases.
- On every entry into Gx, last is set to x.
- Latency:
  - req sampled high in IDLE at edge n -> gnt, sel, an and out (= that requester's data) valid after edge n.
  - While granted, out follows the selected ent with exactly 1 cycle of latency.
- Switching never makes out glitch through blank: between G0 and G1, out changes directly from ent0 data to ent1 data on one edge.
- P_DWELL = 1: with both requesters active, the grant alternates every cycle.
- The counter never exceeds P_DWELL-1 and never wraps.
- Mid-operation reset: on the next edge every output and all state return to their reset values, regardless of req.
- gnt0 and gnt1 are never high together. busy = gnt0 | gnt1.

Decomposition:
- Shared package (localparams): state encodings IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2; BLANK = 7'h7F; AN_NONE = 2'b11; AN_D0 = 2'b10; AN_D1 = 2'b01.
- One sub-module, seg_dwell_counter:
  - Inputs: clk, rst, clr, en. Outputs: cnt, last_cycle (cnt == P_DWELL-1).
- FSM, round-robin pointer and output mux stay in seg_bus_arbiter.

Test Plan:
- Reset: assert rst with req0 = req1 = 1 -> after the edge, out = 7'h7F, an = 11, gnt = 00, busy = 0. Release rst -> gnt0 = 1 on the next edge (last = 1 reset tie-break).
- Single requester: P_DWELL = 4, req0 held high, ent0 = 7'h40 -> gnt0 stays high indefinitely, out = 7'h40, an = 10, cnt cycles 0..3.
- Alternation: P_DWELL = 4, both requesting, ent0 = 7'h40, ent1 = 7'h79 -> G0 for 4 cycles, then G1 for 4 cycles, repeating; out switches 40 -> 79 with no 7F cycle in between.
- Early release: in G1 at cnt = 1, drop req1 with req0 low -> IDLE and out = 7'h7F next edge. Repeat with req0 high -> G0 next edge.
- Data tracking: in G0, change ent0 from 7'h12 to 7'h24 at edge k -> out = 7'h24 after edge k+1.
- Reset mid-slot: rst pulsed in G1 at cnt = 2 -> all outputs at reset values after that edge; first grant after release goes to req0 when both request.
